// File: rtl/bus_reg_slave_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared types and constants for the bus_reg_slave register-bank slave.
//   state_t        : slave FSM states (IDLE, WAIT, RESP, HOLD)
//   BUS_DATA_WIDTH : default data bus width
//   BUS_ADDR_WIDTH : default address bus width
//   clog2_regs()   : index width needed to address a register bank
// -----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int BUS_DATA_WIDTH = 32;
    localparam int BUS_ADDR_WIDTH = 16;

    // Index width for a bank of n registers (n is a power of two, 2..256).
    // Never returns less than 1 so index vectors are always legal.
    function automatic int clog2_regs(input int n);
        int w;
        w = 1;
        for (int i = 1; i <= 8; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bus_reg_slave_if.sv
// -----------------------------------------------------------------------------
// bus_if
// Simple valid/ready request bus between a master and a register slave.
//   valid, read, write, addr, write_data : master -> slave request
//   ready, read_data                     : slave -> master completion
// Modports: master, slave.
// -----------------------------------------------------------------------------
interface bus_if
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int ADDR_WIDTH = BUS_ADDR_WIDTH
) ();

    logic                  valid;
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  ready;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output valid, read, write, addr, write_data,
        input  ready, read_data
    );

    modport slave (
        input  valid, read, write, addr, write_data,
        output ready, read_data
    );

endinterface

// File: rtl/bus_reg_slave_bank.sv
// -----------------------------------------------------------------------------
// bus_reg_bank
// NUM_REGS x DATA_WIDTH register array with one synchronous write port and a
// combinational read port. All registers clear on synchronous reset.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   we, widx, wdata : write enable / index / data
//   ridx, rdata     : combinational read index / data
//   reg_q           : flat copy of all registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module bus_reg_bank
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int NUM_REGS   = 8,
    parameter int IDX_W      = clog2_regs(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [IDX_W-1:0]               widx,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [IDX_W-1:0]               ridx,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    logic [DATA_WIDTH-1:0] mem_reg [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[widx] <= wdata;
        end
    end

    assign rdata = mem_reg[ridx];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = mem_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/bus_reg_slave.sv
// -----------------------------------------------------------------------------
// bus_reg_slave
// Register-bank slave on bus_if. Decodes a word-addressed window
// [BASE_ADDR, BASE_ADDR+NUM_REGS), inserts WAIT_CYCLES wait states and returns
// a one-cycle ready pulse per request, then holds off until valid drops.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : bus_if slave modport (valid/read/write/addr/write_data in,
//                ready/read_data out)
//   reg_q      : flat register contents for downstream control
//   err        : only when BUS_REG_SLAVE_ERR_EN is defined; high in the
//                response cycle on a window miss or a read+write conflict
// -----------------------------------------------------------------------------
module bus_reg_slave
    import bus_pkg::*;
#(
    parameter int                    DATA_WIDTH  = BUS_DATA_WIDTH,
    parameter int                    ADDR_WIDTH  = BUS_ADDR_WIDTH,
    parameter int                    NUM_REGS    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    bus_if.slave                           bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
`ifdef BUS_REG_SLAVE_ERR_EN
    ,
    output logic                           err
`endif
);

    localparam int IDX_W = clog2_regs(NUM_REGS);
    localparam int CNT_W = 4;
    // One extra bit so a window at the top of the address space cannot wrap to 0.
    localparam logic [ADDR_WIDTH:0] WIN_END = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t                state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  rd_reg;
    logic                  wr_reg;
    logic                  hit_reg;
    logic                  ready_reg;
    logic [DATA_WIDTH-1:0] read_data_reg;
`ifdef BUS_REG_SLAVE_ERR_EN
    logic                  err_reg;
`endif

    logic                  live_hit;
    logic [IDX_W-1:0]      live_idx;
    logic                  cur_rd;
    logic                  cur_wr;
    logic                  cur_hit;
    logic [IDX_W-1:0]      cur_idx;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic                  to_resp;
    logic                  bank_we;
    logic [DATA_WIDTH-1:0] bank_rdata;

    assign live_hit = ({1'b0, bus.addr} >= {1'b0, BASE_ADDR}) && ({1'b0, bus.addr} < WIN_END);
    assign live_idx = IDX_W'(bus.addr - BASE_ADDR);

    // With no wait states the bank is written / read on the same edge that
    // samples the request, so the live bus fields are used; otherwise the
    // latched copies are used on the edge leaving WAIT.
    assign cur_rd    = (state_reg == IDLE) ? bus.read       : rd_reg;
    assign cur_wr    = (state_reg == IDLE) ? bus.write      : wr_reg;
    assign cur_hit   = (state_reg == IDLE) ? live_hit       : hit_reg;
    assign cur_idx   = (state_reg == IDLE) ? live_idx       : idx_reg;
    assign cur_wdata = (state_reg == IDLE) ? bus.write_data : wdata_reg;

    assign to_resp = ((state_reg == IDLE) && bus.valid && (WAIT_CYCLES == 0)) ||
                     ((state_reg == WAIT) && (cnt_reg == '0));
    assign bank_we = to_resp && cur_wr && !cur_rd && cur_hit;

    bus_reg_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .we    (bank_we),
        .widx  (cur_idx),
        .wdata (cur_wdata),
        .ridx  (cur_idx),
        .rdata (bank_rdata),
        .reg_q (reg_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            wdata_reg     <= '0;
            rd_reg        <= 1'b0;
            wr_reg        <= 1'b0;
            hit_reg       <= 1'b0;
            ready_reg     <= 1'b0;
            read_data_reg <= '0;
`ifdef BUS_REG_SLAVE_ERR_EN
            err_reg       <= 1'b0;
`endif
        end else begin
            ready_reg <= to_resp;
`ifdef BUS_REG_SLAVE_ERR_EN
            err_reg   <= to_resp && (!cur_hit || (cur_rd && cur_wr));
`endif
            // Reads of a miss or a read+write conflict return zero.
            if (to_resp && cur_rd) begin
                read_data_reg <= (cur_hit && !cur_wr) ? bank_rdata : '0;
            end

            case (state_reg)
                IDLE: begin
                    if (bus.valid) begin
                        idx_reg   <= live_idx;
                        wdata_reg <= bus.write_data;
                        rd_reg    <= bus.read;
                        wr_reg    <= bus.write;
                        hit_reg   <= live_hit;
                        cnt_reg   <= CNT_LOAD;
                        state_reg <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    state_reg <= HOLD;
                end
                HOLD: begin
                    // Stay until the master has released valid so a late drop
                    // cannot be taken as a second request.
                    if (!bus.valid) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_reg;
    assign bus.read_data = read_data_reg;
`ifdef BUS_REG_SLAVE_ERR_EN
    assign err = err_reg;
`endif

endmodule

// File: doc/bus_reg_slave.md
Name: bus_reg_slave

Overview:
- Register-bank slave that terminates the bus_if valid/ready handshake on the consumer side.
- Accepts master_write/master_read style transactions and decodes the address against a base window.
- Stores writes in a NUM_REGS x DATA_WIDTH register array and returns read data with ready after a programmable number of wait states.
- Exposes all register contents as a flat vector for downstream control logic.

Parameters:
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 16, address bus width in bits.
- NUM_REGS, 8, number of registers; power of two, 2..256.
- BASE_ADDR, 16'h0000, first word address of the window. Addressing is word-granular.
- WAIT_CYCLES, 0, wait states inserted before ready; range 0..15.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- valid  input  1  master request strobe; held high until ready is seen.
- read  input  1  read request qualifier.
- write  input  1  write request qualifier.
- addr  input  ADDR_WIDTH  word address; stable while valid.
- write_data  input  DATA_WIDTH  write payload; stable while valid.
- ready  output  1  one-cycle completion pulse.
- read_data  output  DATA_WIDTH  registered read result.
- reg_q  output  NUM_REGS*DATA_WIDTH  flat register contents; reg i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - FSM goes to IDLE.
  - ready=0, read_data=0, all registers 0.
  - Applies mid-transaction; any in-flight request is dropped and never acknowledged.
- FSM states: IDLE, WAIT, RESP, HOLD.
- IDLE:
  - On valid=1, latch addr, write_data, read, write and the hit flag.
  - Hit: BASE_ADDR <= addr < BASE_ADDR+NUM_REGS; index = (addr-BASE_ADDR)[log2(NUM_REGS)-1:0].
  - Go to WAIT if WAIT_CYCLES>0, else RESP. Load the wait counter with WAIT_CYCLES-1.
- WAIT: decrement the counter each cycle; at 0 go to RESP.
- RESP (exactly one cycle): ready=1.
  - Write (write=1, read=0, hit): register updates on the edge entering RESP, so it is visible on reg_q in the RESP cycle.
  - Read (read=1, write=0, hit): read_data loaded on the edge entering RESP.
  - Next state: HOLD.
- HOLD:
  - ready=0; wait until valid is sampled 0, then go to IDLE.
  - Guarantees one request produces exactly one ready, even though the master drops valid late.
- Latency: valid sampled in IDLE at edge k gives ready high in cycle k+1+WAIT_CYCLES. Minimum request spacing is 3+WAIT_CYCLES cycles.
- read_data holds its last value between reads; writes do not change it.
- Miss (address outside window):
  - Write is dropped.
  - Read sets read_data=0.
  - ready is still asserted, so the bus never hangs.
- read=1 and write=1 together: no register change, read_data=0, ready asserted.
- read=0 and write=0: no-op, ready asserted.
- Address wrap: BASE_ADDR+NUM_REGS is computed with ADDR_WIDTH+1 bits, so a window at the top of the address space never aliases to 0.
- Request inputs are ignored outside IDLE; changes during WAIT have no effect.

Optional Feature:
- Macro: BUS_REG_SLAVE_ERR_EN.
- Defined:
  - Adds output port err (1 bit), asserted only in the RESP cycle.
  - err=1 on a miss, or on read and write both high; 0 otherwise; reset value 0.
- Undefined:
  - No err port.
  - Miss and conflict cases are handled silently as described under Behaviour.

Decomposition:
- Package bus_pkg:
  - state_t enum (IDLE, WAIT, RESP, HOLD).
  - Default width constants BUS_DATA_WIDTH=32, BUS_ADDR_WIDTH=16.
  - Function clog2_regs for index width.
- Sub-module bus_reg_bank:
  - Register array with write-enable/index/data inputs and a combinational read port.
  - Drives reg_q.
  - The FSM, wait counter and decode stay in bus_reg_slave.

Test Plan:
- Write/readback, WAIT_CYCLES=0, BASE_ADDR=0:
  - write addr=3, data=32'hDEADBEEF, then read addr=3.
  - ready exactly 1 cycle after each valid sample; read_data=DEADBEEF; reg_q[127:96]=DEADBEEF.
- Wait states, WAIT_CYCLES=3:
  - read addr=0.
  - ready rises on the 4th cycle after valid is sampled, and stays high exactly 1 cycle.
- Out-of-window, BASE_ADDR=16'h0100:
  - write addr=16'h0108, data=1.
  - ready asserted; all regs unchanged.
  - Read addr=16'h00FF returns read_data=0; with BUS_REG_SLAVE_ERR_EN, err=1 in both cases.
- Late valid drop:
  - Master holds valid high 2 cycles after ready.
  - Only one ready pulse; the FSM stays in HOLD until valid=0.
- Reset mid-transaction, WAIT_CYCLES=4:
  - Assert reset during WAIT.
  - ready never pulses; FSM is in IDLE; reg_q=0; read_data=0.
- Conflict:
  - valid with read=1 and write=1 to addr=2 after reg 2 was written with 32'h5.
  - reg 2 stays 5; read_data=0; ready=1; err=1 if enabled.
